// File: rtl/alu_ctrl_if.sv
// Request, ALU-drive and result bundle between a requester, alu_ctrl and the attached combinational ALU.
// slave is the controller's view; master is the requester/ALU side view.
interface alu_ctrl_if #(
  parameter int p_data_width  = 16,
  parameter int p_flags_width = 5
);
  logic                     i_w_in_valid;
  logic                     o_w_in_ready;
  logic [p_data_width-1:0]  i_w_op1;
  logic [p_data_width-1:0]  i_w_op2;
  logic [3:0]               i_w_opcode;
  logic                     i_w_use_carry;
  logic                     i_w_flags_we;
  logic                     i_w_flags_load;
  logic [p_flags_width-1:0] i_w_flags_data;
  logic [p_data_width-1:0]  o_w_alu_op1;
  logic [p_data_width-1:0]  o_w_alu_op2;
  logic [3:0]               o_w_alu_opcode;
  logic                     o_w_alu_carry;
  logic                     o_w_alu_oe;
  logic [p_data_width-1:0]  i_w_alu_out;
  logic [p_flags_width-1:0] i_w_alu_flags;
  logic                     o_w_out_valid;
  logic                     i_w_out_ready;
  logic [p_data_width-1:0]  o_w_result;
  logic [p_flags_width-1:0] o_w_flags;

  modport slave (
    input  i_w_in_valid, i_w_op1, i_w_op2, i_w_opcode, i_w_use_carry, i_w_flags_we,
           i_w_flags_load, i_w_flags_data, i_w_alu_out, i_w_alu_flags, i_w_out_ready,
    output o_w_in_ready, o_w_alu_op1, o_w_alu_op2, o_w_alu_opcode, o_w_alu_carry,
           o_w_alu_oe, o_w_out_valid, o_w_result, o_w_flags
  );

  modport master (
    output i_w_in_valid, i_w_op1, i_w_op2, i_w_opcode, i_w_use_carry, i_w_flags_we,
           i_w_flags_load, i_w_flags_data, i_w_alu_out, i_w_alu_flags, i_w_out_ready,
    input  o_w_in_ready, o_w_alu_op1, o_w_alu_op2, o_w_alu_opcode, o_w_alu_carry,
           o_w_alu_oe, o_w_out_valid, o_w_result, o_w_flags
  );
endinterface

// File: rtl/alu_ctrl.sv
// Sequences one op through a combinational ALU (IDLE->EXEC->DONE), holding a flags register; result valid two edges
// after the request is presented. Accepts only in IDLE, holds the result in DONE until out_ready; nothing is queued.
module alu_ctrl #(
  parameter int p_data_width  = 16,
  parameter int p_flags_width = 5
) (
  input logic       i_w_clk,
  input logic       i_w_rst_n,
  alu_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [p_data_width-1:0]  op1_q, op1_d;
  logic [p_data_width-1:0]  op2_q, op2_d;
  logic [3:0]               opcode_q, opcode_d;
  logic                     use_carry_q, use_carry_d;
  logic                     flags_we_q, flags_we_d;
  logic [p_data_width-1:0]  result_q, result_d;
  logic [p_flags_width-1:0] flags_q, flags_d;

  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      state_q     <= S_IDLE;
      op1_q       <= '0;
      op2_q       <= '0;
      opcode_q    <= '0;
      use_carry_q <= 1'b0;
      flags_we_q  <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      opcode_q    <= opcode_d;
      use_carry_q <= use_carry_d;
      flags_we_q  <= flags_we_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    opcode_d    = opcode_q;
    use_carry_d = use_carry_q;
    flags_we_d  = flags_we_q;
    result_d    = result_q;
    flags_d     = flags_q;
    case (state_q)
      S_IDLE: begin
        // A direct load lands before EXEC, so a same-edge accepted op sees the loaded C.
        if (bus.i_w_flags_load) begin
          flags_d = bus.i_w_flags_data;
        end
        if (bus.i_w_in_valid) begin
          op1_d       = bus.i_w_op1;
          op2_d       = bus.i_w_op2;
          opcode_d    = bus.i_w_opcode;
          use_carry_d = bus.i_w_use_carry;
          flags_we_d  = bus.i_w_flags_we;
          state_d     = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d = bus.i_w_alu_out;
        if (flags_we_q) begin
          flags_d = bus.i_w_alu_flags;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.i_w_out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.o_w_in_ready   = (state_q == S_IDLE);
  assign bus.o_w_out_valid  = (state_q == S_DONE);
  assign bus.o_w_alu_oe     = (state_q == S_EXEC);
  assign bus.o_w_alu_carry  = (state_q == S_EXEC) & use_carry_q & flags_q[0];
  assign bus.o_w_alu_op1    = op1_q;
  assign bus.o_w_alu_op2    = op2_q;
  assign bus.o_w_alu_opcode = opcode_q;
  assign bus.o_w_result     = result_q;
  assign bus.o_w_flags      = flags_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: directed cases with literal expectations, then random traffic against a transaction-level model.
module tb_alu_ctrl;
  localparam int DW = 16;
  localparam int FW = 5;
  localparam logic [3:0] OP_ADC = 4'd0;
  localparam logic [3:0] OP_SBB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_ctrl_if #(.p_data_width(DW), .p_flags_width(FW)) bus ();

  alu_ctrl #(.p_data_width(DW), .p_flags_width(FW)) dut (
    .i_w_clk  (clk),
    .i_w_rst_n(rst_n),
    .bus      (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Flags {P,S,Z,O,C}; P set on even parity of the full result.
  function automatic logic [20:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] opc, input logic cin);
    logic [16:0] w;
    logic [15:0] r;
    logic        c, o;
    w = '0; c = 1'b0; o = 1'b0;
    case (opc)
      OP_ADC: begin
        w = {1'b0, a} + {1'b0, b} + {16'b0, cin};
        r = w[15:0]; c = w[16]; o = (a[15] == b[15]) && (r[15] != a[15]);
      end
      OP_SBB: begin
        w = {1'b0, a} - {1'b0, b} - {16'b0, cin};
        r = w[15:0]; c = w[16]; o = (a[15] != b[15]) && (r[15] != a[15]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = a;
    endcase
    return {~^r, r[15], (r == 16'h0000), o, c, r};
  endfunction

  // The attached ALU; garbage when not enabled so off-cycle sampling shows up.
  always_comb begin
    if (bus.o_w_alu_oe) begin
      {bus.i_w_alu_flags, bus.i_w_alu_out} =
        ref_alu(bus.o_w_alu_op1, bus.o_w_alu_op2, bus.o_w_alu_opcode, bus.o_w_alu_carry);
    end else begin
      bus.i_w_alu_flags = 5'h1F;
      bus.i_w_alu_out   = 16'hDEAD;
    end
  end

  // Transaction model: the held request plus how far it has progressed (0 none, 1 executing, 2 result waiting).
  typedef struct {
    logic [15:0] op1;
    logic [15:0] op2;
    logic [3:0]  opc;
    logic        uc;
    logic        we;
  } req_t;

  req_t        m_req = '{op1: 16'h0, op2: 16'h0, opc: 4'h0, uc: 1'b0, we: 1'b0};
  int          m_stage  = 0;
  logic [15:0] m_result = '0;
  logic [4:0]  m_flags  = '0;
  logic [20:0] m_alu;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stage  = 0;
      m_req    = '{op1: 16'h0, op2: 16'h0, opc: 4'h0, uc: 1'b0, we: 1'b0};
      m_result = '0;
      m_flags  = '0;
    end else if (m_stage == 0) begin
      if (bus.i_w_flags_load) m_flags = bus.i_w_flags_data;
      if (bus.i_w_in_valid) begin
        m_req = '{op1: bus.i_w_op1, op2: bus.i_w_op2, opc: bus.i_w_opcode,
                  uc: bus.i_w_use_carry, we: bus.i_w_flags_we};
        m_stage = 1;
      end
    end else if (m_stage == 1) begin
      m_alu    = ref_alu(m_req.op1, m_req.op2, m_req.opc, m_req.uc & m_flags[0]);
      m_result = m_alu[15:0];
      if (m_req.we) m_flags = m_alu[20:16];
      m_stage = 2;
    end else if (bus.i_w_out_ready) begin
      m_stage = 0;
    end
  end

  always @(negedge clk) begin
    chk("m_in_ready",  32'(bus.o_w_in_ready),   32'(m_stage == 0));
    chk("m_out_valid", 32'(bus.o_w_out_valid),  32'(m_stage == 2));
    chk("m_alu_oe",    32'(bus.o_w_alu_oe),     32'(m_stage == 1));
    chk("m_alu_carry", 32'(bus.o_w_alu_carry),  32'((m_stage == 1) & m_req.uc & m_flags[0]));
    chk("m_alu_op1",   32'(bus.o_w_alu_op1),    32'(m_req.op1));
    chk("m_alu_op2",   32'(bus.o_w_alu_op2),    32'(m_req.op2));
    chk("m_alu_opc",   32'(bus.o_w_alu_opcode), 32'(m_req.opc));
    chk("m_result",    32'(bus.o_w_result),     32'(m_result));
    chk("m_flags",     32'(bus.o_w_flags),      32'(m_flags));
  end

  task automatic drive_idle();
    bus.i_w_in_valid   = 1'b0;
    bus.i_w_op1        = '0;
    bus.i_w_op2        = '0;
    bus.i_w_opcode     = '0;
    bus.i_w_use_carry  = 1'b0;
    bus.i_w_flags_we   = 1'b0;
    bus.i_w_flags_load = 1'b0;
    bus.i_w_flags_data = '0;
    bus.i_w_out_ready  = 1'b0;
  endtask

  // Request presented after edge k, accepted at k+1, result checked after k+2.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] opc, input logic uc, input logic we,
                        input logic fl_load, input logic [4:0] fl_data, input logic exp_cin,
                        input logic [15:0] exp_res, input logic [4:0] exp_fl, input int hold);
    int guard;
    guard = 0;
    @(posedge clk); #1;
    bus.i_w_out_ready = 1'b1;
    while (!bus.o_w_in_ready && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    bus.i_w_out_ready = 1'b0;
    chk({tag, "_idle"}, 32'(bus.o_w_in_ready), 32'd1);
    bus.i_w_in_valid   = 1'b1;
    bus.i_w_op1        = a;
    bus.i_w_op2        = b;
    bus.i_w_opcode     = opc;
    bus.i_w_use_carry  = uc;
    bus.i_w_flags_we   = we;
    bus.i_w_flags_load = fl_load;
    bus.i_w_flags_data = fl_data;
    @(posedge clk); #1;
    bus.i_w_in_valid   = 1'b0;
    bus.i_w_flags_load = 1'b0;
    chk({tag, "_exec_oe"},    32'(bus.o_w_alu_oe),    32'd1);
    chk({tag, "_exec_cin"},   32'(bus.o_w_alu_carry), 32'(exp_cin));
    chk({tag, "_exec_valid"}, 32'(bus.o_w_out_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_valid"},  32'(bus.o_w_out_valid), 32'd1);
    chk({tag, "_result"}, 32'(bus.o_w_result),    32'(exp_res));
    chk({tag, "_flags"},  32'(bus.o_w_flags),     32'(exp_fl));
    bus.i_w_in_valid = (hold > 0);
    bus.i_w_op1      = 16'h5A5A;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"},  32'(bus.o_w_out_valid), 32'd1);
      chk({tag, "_hold_ready"},  32'(bus.o_w_in_ready),  32'd0);
      chk({tag, "_hold_result"}, 32'(bus.o_w_result),    32'(exp_res));
    end
    bus.i_w_in_valid  = 1'b0;
    bus.i_w_out_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_w_out_ready = 1'b0;
    chk({tag, "_back_idle"},   32'(bus.o_w_in_ready), 32'd1);
    chk({tag, "_idle_result"}, 32'(bus.o_w_result),   32'(exp_res));
    chk({tag, "_no_recapture"}, 32'(bus.o_w_alu_op1), 32'(a));
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      default: return 16'($urandom());
    endcase
  endfunction

  initial begin
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(bus.o_w_in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.o_w_out_valid), 32'd0);
    chk("rst_alu_oe",    32'(bus.o_w_alu_oe),    32'd0);
    chk("rst_result",    32'(bus.o_w_result),    32'd0);
    chk("rst_flags",     32'(bus.o_w_flags),     32'd0);
    rst_n = 1'b1;

    run_op("adc_ovf",   16'h7FFF, 16'h0001, OP_ADC, 1'b0, 1'b1, 1'b0, 5'b00000, 1'b0, 16'h8000, 5'b01010, 0);
    run_op("adc_wrap",  16'hFFFF, 16'h0001, OP_ADC, 1'b0, 1'b1, 1'b0, 5'b00000, 1'b0, 16'h0000, 5'b10101, 5);
    run_op("adc_cin",   16'h0000, 16'h0000, OP_ADC, 1'b1, 1'b1, 1'b0, 5'b00000, 1'b1, 16'h0001, 5'b00000, 0);
    run_op("and_nowe",  16'h00F0, 16'h0F00, OP_AND, 1'b0, 1'b0, 1'b1, 5'b10101, 1'b0, 16'h0000, 5'b10101, 0);
    run_op("load_cin",  16'h0001, 16'h0001, OP_ADC, 1'b1, 1'b1, 1'b1, 5'b00001, 1'b1, 16'h0003, 5'b10000, 0);

    // Reset landing in the middle of an execute cycle.
    @(posedge clk); #1;
    bus.i_w_in_valid = 1'b1;
    bus.i_w_op1      = 16'hFFFF;
    bus.i_w_op2      = 16'h0001;
    bus.i_w_opcode   = OP_ADC;
    bus.i_w_flags_we = 1'b1;
    @(posedge clk); #1;
    bus.i_w_in_valid = 1'b0;
    chk("rstx_pre_oe", 32'(bus.o_w_alu_oe), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstx_out_valid", 32'(bus.o_w_out_valid), 32'd0);
    chk("rstx_flags",     32'(bus.o_w_flags),     32'd0);
    chk("rstx_alu_oe",    32'(bus.o_w_alu_oe),    32'd0);
    chk("rstx_result",    32'(bus.o_w_result),    32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstx_idle",      32'(bus.o_w_in_ready),  32'd1);
    chk("rstx_no_resume", 32'(bus.o_w_out_valid), 32'd0);

    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      bus.i_w_in_valid   = ($urandom_range(0, 1) == 1);
      bus.i_w_op1        = pick();
      bus.i_w_op2        = pick();
      bus.i_w_opcode     = 4'($urandom_range(0, 5));
      bus.i_w_use_carry  = ($urandom_range(0, 1) == 1);
      bus.i_w_flags_we   = ($urandom_range(0, 3) != 0);
      bus.i_w_flags_load = ($urandom_range(0, 5) == 0);
      bus.i_w_flags_data = 5'($urandom());
      bus.i_w_out_ready  = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
    end

    @(posedge clk); #1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach its end, expected completion before 500000");
    $fatal(1);
  end

endmodule
